// File: rtl/sram_responder.sv
// Block-RAM stand-in for the SLC-3 active-low SRAM strobe interface, with multi-cycle read/write timing.
// Optional MEM_IO_MAP_EN maps address all-ones to Switches (read) / Hex_out (write).
module sram_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_to_mem,
`ifdef MEM_IO_MAP_EN
    input  logic [15:0]       Switches,
    output logic [15:0]       Hex_out,
`endif
    output logic [DATA_W-1:0] Data_from_mem,
    output logic              Data_valid,
    output logic              Busy,
    output logic              Err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LO_W  = DATA_W / 2;
    localparam int HI_W  = DATA_W - LO_W;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          cnt_inc;
    logic [ADDR_W-1:0]   a_lat_q, a_lat_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q;

    logic                rd, wr, conflict, addr_match;
    logic                rd_fire, commit, wr_fire;
    logic                io_hit;
    logic [DEPTH_LOG2-1:0] idx;

    logic [HI_W-1:0] mem_hi [DEPTH];
    logic [LO_W-1:0] mem_lo [DEPTH];

    assign rd         = ~Mem_CE & ~Mem_OE & Mem_WE;
    assign wr         = ~Mem_CE & ~Mem_WE;
    assign conflict   = ~Mem_CE & ~Mem_OE & ~Mem_WE;
    assign addr_match = (ADDR == a_lat_q);
    assign cnt_inc    = cnt_q + 3'd1;
    // Every read fetch and write commit happens with ADDR equal to the
    // (new or held) latched address, so the live bus indexes the RAM.
    assign idx        = ADDR[DEPTH_LOG2-1:0];

`ifdef MEM_IO_MAP_EN
    assign io_hit = (ADDR == {ADDR_W{1'b1}});
`else
    assign io_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_lat_d = a_lat_q;
        valid_d = valid_q;
        err_d   = err_q;
        rd_fire = 1'b0;
        commit  = 1'b0;
        if (conflict) begin
            err_d = 1'b1;
        end
        if (wr) begin
            valid_d = 1'b0;
            if (state_q == WR_WAIT && addr_match) begin
                cnt_d = cnt_inc;
                if (cnt_inc == 3'(WR_LAT)) begin
                    commit  = 1'b1;
                    state_d = WR_DONE;
                end
            end else if (state_q != WR_DONE) begin
                // Address moving under a pending write is a protocol error.
                if (state_q == WR_WAIT) begin
                    err_d = 1'b1;
                end
                state_d = WR_WAIT;
                cnt_d   = 3'd1;
                a_lat_d = ADDR;
                if (WR_LAT == 1) begin
                    commit  = 1'b1;
                    state_d = WR_DONE;
                end
            end
        end else if (rd) begin
            if (state_q == RD_WAIT && addr_match) begin
                cnt_d = cnt_inc;
                if (cnt_inc == 3'(RD_LAT - 1)) begin
                    rd_fire = 1'b1;
                    valid_d = 1'b1;
                    state_d = RD_HOLD;
                end
            end else if (!(state_q == RD_HOLD && addr_match)) begin
                state_d = RD_WAIT;
                cnt_d   = 3'd1;
                a_lat_d = ADDR;
                valid_d = 1'b0;
                if (RD_LAT == 2) begin
                    rd_fire = 1'b1;
                    valid_d = 1'b1;
                    state_d = RD_HOLD;
                end
            end
        end else begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            valid_d = 1'b0;
        end
    end

    assign wr_fire = commit & ~Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            a_lat_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_lat_q <= a_lat_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (rd_fire) begin
`ifdef MEM_IO_MAP_EN
            if (io_hit) begin
                rdata_q <= DATA_W'(Switches);
            end else begin
                rdata_q <= {mem_hi[idx], mem_lo[idx]};
            end
`else
            rdata_q <= {mem_hi[idx], mem_lo[idx]};
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire && !io_hit && !Mem_UB) begin
            mem_hi[idx] <= Data_to_mem[DATA_W-1:LO_W];
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire && !io_hit && !Mem_LB) begin
            mem_lo[idx] <= Data_to_mem[LO_W-1:0];
        end
    end

`ifdef MEM_IO_MAP_EN
    logic [15:0] hex_q;
    logic [15:0] wdata16;
    assign wdata16 = 16'(Data_to_mem);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= 16'h0000;
        end else if (wr_fire && io_hit) begin
            hex_q <= {Mem_UB ? hex_q[15:8] : wdata16[15:8],
                      Mem_LB ? hex_q[7:0]  : wdata16[7:0]};
        end
    end

    assign Hex_out = hex_q;
`endif

    assign Data_from_mem = rdata_q;
    // Valid is withdrawn combinationally as soon as the bus address moves away.
    assign Data_valid    = valid_q & addr_match;
    assign Busy          = (state_q != IDLE);
    assign Err           = err_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Memory-side responder for the SLC-3 datapath's asynchronous-style SRAM strobe interface (active-low CE/UB/LB/OE/WE). It models on-chip memory with the same multi-cycle timing the control unit drives: 2-cycle reads with data sampled in the second cycle, and 2-cycle writes. It sits between the datapath's MAR/MDR and a synchronous block RAM. It replaces the external SRAM for simulation and FPGA bring-up.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address bus width
DEPTH_LOG2, 10, log2 of words stored; ADDR[DEPTH_LOG2-1:0] indexes memory, upper bits ignored (aliasing)
RD_LAT, 2, consecutive read-strobe cycles until data valid (legal range 2..7)
WR_LAT, 2, consecutive write-strobe cycles until commit (legal range 1..7)

Ports:
Clk  in  1  clock, all logic on rising edge
Reset  in  1  synchronous, active-high
Mem_CE  in  1  chip enable, active low
Mem_UB  in  1  upper byte enable, active low
Mem_LB  in  1  lower byte enable, active low
Mem_OE  in  1  output enable, active low
Mem_WE  in  1  write enable, active low
ADDR  in  ADDR_W  word address (MAR)
Data_to_mem  in  DATA_W  write data (MDR)
Data_from_mem  out  DATA_W  registered read data
Data_valid  out  1  Data_from_mem valid for current read
Busy  out  1  state != IDLE
Err  out  1  sticky protocol error

Behaviour:
- Reset is synchronous, active-high; clock Clk. On Reset: state IDLE, counter 0, Data_from_mem 0, Data_valid 0, Err 0. Memory contents are not cleared.
- Decoded strobes, sampled each edge:
  - rd = ~CE & ~OE & WE
  - wr = ~CE & ~WE (WE dominates OE)
  - CE high means idle regardless of OE/WE.
- FSM states: IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_DONE. A 3-bit cycle counter cnt tracks progress; ADDR is latched at operation start into a_lat.
- IDLE:
  - rd -> RD_WAIT, cnt=1, a_lat=ADDR.
  - wr -> WR_WAIT, cnt=1, a_lat=ADDR; if WR_LAT==1, commit on this edge and go to WR_DONE.
- RD_WAIT:
  - rd with ADDR==a_lat: cnt++.
  - On the edge where cnt reaches RD_LAT-1: Data_from_mem <= mem[a_lat], Data_valid <= 1, state -> RD_HOLD.
  - Consequence: with RD_LAT=2, data is valid during the 2nd strobe cycle, so a load-MDR in that cycle captures it.
- RD_HOLD: while rd and ADDR==a_lat, hold Data_valid=1 and Data_from_mem unchanged.
- Read, address change: rd with ADDR!=a_lat in RD_WAIT or RD_HOLD restarts the read. Go to RD_WAIT, cnt=1, a_lat=ADDR, Data_valid=0.
- WR_WAIT:
  - wr with ADDR==a_lat: cnt++.
  - On the edge where cnt reaches WR_LAT, commit and go to WR_DONE.
  - Commit writes mem[a_lat] high byte if ~UB and low byte if ~LB, from Data_to_mem sampled at that edge.
- WR_DONE: stays while wr; no second commit. Exactly one commit per strobe assertion.
- Early release (strobe drops before completion): abort, return to IDLE.
  - Read abort: Data_valid=0, Data_from_mem keeps its last value.
  - Write abort: no commit.
- Back-to-back operations: any state with no rd and no wr returns to IDLE on the next edge. A direct switch rd->wr or wr->rd is treated as release plus new start in the same edge (latch the new a_lat, cnt=1).
- Data_valid deasserts on the edge after rd drops.
- Err is set (sticky until Reset) when:
  - ~CE & ~OE & ~WE is sampled; the write is still performed, or
  - ADDR changes during WR_WAIT; the write aborts, then restarts at the new address.
- Read-after-write: a read started the cycle after a commit returns the new data.
- Reset mid-operation: any pending write is dropped uncommitted; outputs return to reset values.

Optional Feature:
MEM_IO_MAP_EN
- Defined: adds ports Switches (in, 16) and Hex_out (out, 16, reset 0). Address 16'hFFFF (full ADDR_W compare) is I/O-mapped:
  - Reads return Switches, registered at the same latency as memory.
  - Writes commit to Hex_out, honoring UB/LB, and do not touch mem.
- Undefined: no extra ports; 16'hFFFF aliases into memory like any other address.

Test Plan:
- Reset with outputs disturbed -> Data_from_mem=0, Data_valid=0, Busy=0, Err=0 on the next cycle.
- Write 16'hBEEF to addr 16'h0012 (CE=0, WE=0, UB=LB=0, 2 cycles), then read 0x0012 (OE=0, 2 cycles) -> Data_valid=1 and Data_from_mem=16'hBEEF in the 2nd read cycle.
- Write 16'h1234 with UB=1, LB=0 over 16'hBEEF at 0x0012 -> subsequent read returns 16'hBE34.
- WE low for only 1 cycle with WR_LAT=2, data 16'h0000 to 0x0012 -> no commit; read returns 16'hBE34.
- OE and WE both low, data 16'h5A5A to 0x0020 -> Err=1 and stays 1; read of 0x0020 returns 16'h5A5A.
- ADDR switches 0x0012->0x0020 in the 2nd read cycle -> Data_valid=0 that cycle, then 16'h5A5A valid one cycle later. Same case with RD_LAT=3 -> valid in 3rd cycle.
- MEM_IO_MAP_EN defined: write 16'h00C3 to 0xFFFF -> Hex_out=16'h00C3. With Switches=16'h0F0F, read 0xFFFF -> 16'h0F0F.
